// File: rtl/song_play_ctrl.sv
// Song playback scheduler: shares one tone generator between free-play keys and ROM songs.
// Latency: start -> first note on note_out 3 cycles; key_note -> note_out 1 cycle; all outputs registered.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE, pause freezes PLAY/GAP.
// Optional feature macro: PLAY_LOOP_EN (loop the song forever instead of ending in DONE).
// Note: rst_n is an active-HIGH synchronous reset despite its name.
module song_play_ctrl #(
    parameter int BEAT_CYC = 25_000_000,
    parameter int GAP_CYC  = 2_500_000,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        key_note,
    input  logic [1:0]        song_sel,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W+1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [4:0]        note_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int CNT_MAX = (BEAT_CYC > GAP_CYC) ? BEAT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] BEAT_LD  = CNT_W'(BEAT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [4:0]       CODE_END = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_GAP,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    state_t              r_saved, w_saved_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic [1:0]          r_song, w_song_nxt;
    logic [4:0]          r_note, w_note_nxt;
    logic [4:0]          r_note_out, w_note_out_nxt;
    logic                r_busy;
    logic                r_done, w_done_nxt;
    logic [ADDR_W+1:0]   r_rom_addr, w_rom_addr_nxt;
    logic                w_end;
    logic                w_last_idx;
    logic [CNT_W-1:0]    w_cnt_hold;

    // Only the seven solfege codes sound; rests and unknown codes are silence.
    function automatic logic [4:0] decode(input logic [4:0] code);
        return (code >= 5'd8 && code <= 5'd14) ? code : 5'd0;
    endfunction

    assign w_last_idx = (r_idx == {ADDR_W{1'b1}});
    // The cycle on which pause is sampled still counts toward the beat/gap.
    assign w_cnt_hold = (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        w_state_nxt    = r_state;
        w_saved_nxt    = r_saved;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_song_nxt     = r_song;
        w_note_nxt     = r_note;
        w_note_out_nxt = 5'd0;
        w_done_nxt     = 1'b0;
        w_end          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_note_out_nxt = (key_note == 3'd0) ? 5'd0 : {2'b00, key_note} + 5'd7;
                if (start && !stop) begin
                    w_state_nxt    = S_FETCH;
                    w_song_nxt     = song_sel;
                    w_idx_nxt      = '0;
                    w_note_out_nxt = 5'd0;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                if (rom_data == CODE_END) begin
                    w_end = 1'b1;
                end else begin
                    w_note_nxt     = decode(rom_data);
                    w_note_out_nxt = decode(rom_data);
                    w_state_nxt    = S_PLAY;
                    w_cnt_nxt      = BEAT_LD;
                end
            end
            S_PLAY: begin
                w_note_out_nxt = r_note;
                if (pause) begin
                    w_state_nxt    = S_PAUSED;
                    w_saved_nxt    = S_PLAY;
                    w_cnt_nxt      = w_cnt_hold;
                    w_note_out_nxt = 5'd0;
                end else if (r_cnt == '0) begin
                    w_state_nxt    = S_GAP;
                    w_cnt_nxt      = GAP_LD;
                    w_note_out_nxt = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (pause) begin
                    w_state_nxt = S_PAUSED;
                    w_saved_nxt = S_GAP;
                    w_cnt_nxt   = w_cnt_hold;
                end else if (r_cnt == '0) begin
                    // Last slot finished: behave as if the end marker was read.
                    if (w_last_idx) begin
                        w_end = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = r_idx + ADDR_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_PAUSED: begin
                if (pause) begin
                    w_state_nxt    = r_saved;
                    w_note_out_nxt = (r_saved == S_PLAY) ? r_note : 5'd0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_end) begin
`ifdef PLAY_LOOP_EN
            w_state_nxt = S_FETCH;
            w_idx_nxt   = '0;
`else
            w_state_nxt = S_DONE;
`endif
            w_done_nxt  = 1'b1;
        end

        if (stop && r_state != S_IDLE) begin
            w_state_nxt    = S_IDLE;
            w_note_out_nxt = 5'd0;
            w_done_nxt     = 1'b0;
        end

        w_rom_addr_nxt = (w_state_nxt == S_IDLE) ? {song_sel, {ADDR_W{1'b0}}}
                                                 : {w_song_nxt, w_idx_nxt};
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_saved    <= S_PLAY;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_song     <= 2'd0;
            r_note     <= 5'd0;
            r_note_out <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_saved    <= w_saved_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_song     <= w_song_nxt;
            r_note     <= w_note_nxt;
            r_note_out <= w_note_out_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_rom_addr <= w_rom_addr_nxt;
        end
    end

    assign rom_addr = r_rom_addr;
    assign note_out = r_note_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign note_idx = r_idx;

endmodule

// File: tb/tb_song_play_ctrl.sv
// Bench for song_play_ctrl: directed steps plus randomized songs against a per-cycle song model.
// Latency: one check set per clock, sampled 1 time unit after the rising edge.
// Backpressure: none; inputs are driven right after each sampling point.
module tb_song_play_ctrl;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int AW   = 3;
    localparam int SLOTS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    key_note;
    logic [1:0]    song_sel;
    logic          start, stop, pause;
    logic [AW+1:0] rom_addr;
    logic [4:0]    rom_data;
    logic [4:0]    note_out;
    logic          busy, done;
    logic [AW-1:0] note_idx;

    always #5 clk = ~clk;

    song_play_ctrl #(.BEAT_CYC(BEAT), .GAP_CYC(GAP), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .key_note(key_note), .song_sel(song_sel),
        .start(start), .stop(stop), .pause(pause), .rom_addr(rom_addr),
        .rom_data(rom_data), .note_out(note_out), .busy(busy), .done(done),
        .note_idx(note_idx)
    );

    // Synchronous song ROM: data valid one cycle after the address.
    logic [4:0] rom [0:4*SLOTS-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [4:0]    note;
        logic          bsy;
        logic          dn;
        logic [AW-1:0] idx;
        logic [AW+1:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int nt, input int b, input int d, input int ix, input int ad);
        exp_t e;
        e.note = 5'(nt);
        e.bsy  = 1'(b);
        e.dn   = 1'(d);
        e.idx  = AW'(ix);
        e.addr = (AW+2)'(ad);
        return e;
    endfunction

    // Expected per-cycle outputs for one pass of a song, starting the cycle after start.
    task automatic build(input int song);
        int last_k;
        int code;
        int snd;
        int base;
        base   = song * SLOTS;
        last_k = SLOTS - 1;
        q.delete();
        for (int k = 0; k < SLOTS; k++) begin
            code = int'(rom[base + k]);
            q.push_back(mk(0, 1, 0, k, base + k));
            q.push_back(mk(0, 1, 0, k, base + k));
            if (code == 31) begin
                last_k = k;
                break;
            end
            snd = (code >= 8 && code <= 14) ? code : 0;
            repeat (BEAT) q.push_back(mk(snd, 1, 0, k, base + k));
            repeat (GAP)  q.push_back(mk(0, 1, 0, k, base + k));
        end
`ifdef PLAY_LOOP_EN
        q.push_back(mk(0, 1, 1, 0, base));
`else
        q.push_back(mk(0, 1, 1, last_k, base + last_k));
`endif
    endtask

    task automatic run_song(input int song);
        exp_t e;
        build(song);
        song_sel = 2'(song);
        start    = 1'b1;
        while (q.size() > 0) begin
            tick();
            start    = 1'b0;
            e        = q.pop_front();
            key_note = 3'($urandom_range(0, 7));
            song_sel = 2'($urandom_range(0, 3));
            chk("song_note", 32'(note_out), 32'(e.note));
            chk("song_busy", 32'(busy), 32'(e.bsy));
            chk("song_done", 32'(done), 32'(e.dn));
            chk("song_idx", 32'(note_idx), 32'(e.idx));
            chk("song_addr", 32'(rom_addr), 32'(e.addr));
        end
`ifdef PLAY_LOOP_EN
        stop = 1'b1;
        tick();
        stop = 1'b0;
`else
        tick();
`endif
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd0);
        chk("end_note", 32'(note_out), 32'd0);
    endtask

    task automatic fill_random(input int song);
        int r;
        for (int k = 0; k < SLOTS; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      rom[song*SLOTS + k] = 5'd0;
            else if (r <= 7) rom[song*SLOTS + k] = 5'(7 + r);
            else if (r == 8) rom[song*SLOTS + k] = 5'd31;
            else             rom[song*SLOTS + k] = 5'($urandom_range(1, 30));
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4*SLOTS; i++) rom[i] = 5'd0;
        rom[SLOTS + 0] = 5'd8;
        rom[SLOTS + 1] = 5'd10;
        rom[SLOTS + 2] = 5'd0;
        rom[SLOTS + 3] = 5'd31;
        for (int i = 0; i < SLOTS; i++) rom[2*SLOTS + i] = 5'd9;

        // Reset with busy-looking inputs present: reset must win.
        rst_n = 1'b1; key_note = 3'd4; song_sel = 2'd2;
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        tick(); tick();
        chk("rst_note", 32'(note_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(note_idx), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b0;

        // Free play in IDLE.
        key_note = 3'd3;
        tick();
        chk("fp_note3", 32'(note_out), 32'd10);
        chk("fp_busy", 32'(busy), 32'd0);
        chk("idle_addr", 32'(rom_addr), 32'd16);
        key_note = 3'd0;
        tick();
        chk("fp_note0", 32'(note_out), 32'd0);

        // Full playback of song 1 and its end.
        run_song(1);

        // Pause during the 2nd beat cycle of the first note.
        key_note = 3'd0;
        song_sel = 2'd1;
        start    = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("p_note_c3", 32'(note_out), 32'd8);
        tick();
        chk("p_note_c4", 32'(note_out), 32'd8);
        pause = 1'b1;
        tick(); pause = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            chk("p_silent", 32'(note_out), 32'd0);
            chk("p_idx", 32'(note_idx), 32'd0);
            chk("p_busy", 32'(busy), 32'd1);
        end
        pause = 1'b1;
        tick(); pause = 1'b0;
        chk("p_resume1", 32'(note_out), 32'd8);
        tick();
        chk("p_resume2", 32'(note_out), 32'd8);
        tick();
        chk("p_gap1", 32'(note_out), 32'd0);
        tick();
        chk("p_gap2", 32'(note_out), 32'd0);
        tick();
        chk("p_fetch_idx", 32'(note_idx), 32'd1);
        chk("p_fetch_addr", 32'(rom_addr), 32'd9);
        tick(); tick();
        chk("p_note10", 32'(note_out), 32'd10);

        // Stop and start together mid-note: stop wins.
        stop = 1'b1; start = 1'b1;
        tick(); stop = 1'b0; start = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_note", 32'(note_out), 32'd0);
        tick();
        chk("stop_stay_idle", 32'(busy), 32'd0);

        // Replay from index 0, then the all-notes song that runs off the last slot.
        run_song(1);
        run_song(2);

        // Randomized songs.
        for (int it = 0; it < 6; it++) begin
            k = (it % 2 == 0) ? 3 : 0;
            fill_random(k);
            run_song(k);
        end

        // Randomized free play: one-cycle latency.
        for (int it = 0; it < 10; it++) begin
            k = int'($urandom_range(0, 7));
            key_note = 3'(k);
            tick();
            chk("fp_rand_note", 32'(note_out), (k == 0) ? 32'd0 : 32'(k + 7));
            chk("fp_rand_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
